// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore sequencing FSM with memory wait states,
// ALU operation decoder and branch-condition resolver for a shared-memory datapath.
module mc_controller #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Neg,
    input  logic                 Carry,
    input  logic                 Ovf,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Retire,
    output logic                 Illegal
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);
    localparam bit         ALU_EXT   = (ALUCTRL_W >= 4);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(9);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JALRADR,
        S_JAL,
        S_LUI,
        S_AUIPC,
        S_BRANCH,
        S_ILLEGAL
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] wcnt;
    logic       mem_state;
    logic       last_cycle;
    logic [1:0] alu_op;
    logic       taken;

    assign mem_state  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign last_cycle = (wcnt == WAIT_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            wcnt  <= '0;
        end else begin
            state <= next_state;
            if (mem_state && !last_cycle)
                wcnt <= wcnt + 4'd1;
            else
                wcnt <= '0;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Neg ^ Ovf;
            3'b101:  taken = !(Neg ^ Ovf);
            3'b110:  taken = !Carry;
            3'b111:  taken = Carry;
            default: taken = 1'b0;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        Retire     = 1'b0;
        Illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                ResultSrc = 2'b10;
                ALUSrcB   = 2'b10;
                if (last_cycle) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALRADR;
                    OP_BR:             next_state = S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (last_cycle)
                    next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                Retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                if (last_cycle) begin
                    MemWrite   = 1'b1;
                    Retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                Retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JALRADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                next_state = S_JAL;
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCWrite    = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                next_state = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                PCWrite    = taken;
                Retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase

        // A reset cycle must never commit architectural state or report completion.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Retire   = 1'b0;
            Illegal  = 1'b0;
        end
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_I, OP_JALR: ImmSrc = 3'b000;
            OP_STORE:               ImmSrc = 3'b001;
            OP_BR:                  ImmSrc = 3'b010;
            OP_JAL:                 ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:       ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            2'b00: ALUControl = ALU_ADD;
            2'b01: ALUControl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    3'b011:  ALUControl = ALU_EXT ? ALU_SLTU : ALU_ADD;
                    3'b001:  ALUControl = ALU_EXT ? ALU_SLL : ALU_ADD;
                    3'b101:  ALUControl = ALU_EXT ? (funct7b5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
                    default: ALUControl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: two instances (3-bit ALU code without wait
// states, 4-bit ALU code with two wait states) checked cycle by cycle.
module tb_mc_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ret;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t  v;
        string tag;
    } exp_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IM_I = 3'b000;
    localparam logic [2:0] IM_S = 3'b001;
    localparam logic [2:0] IM_B = 3'b010;
    localparam logic [2:0] IM_J = 3'b011;
    localparam logic [2:0] IM_U = 3'b100;

    logic       clk = 1'b0;
    logic       rst  [2];
    logic [6:0] op   [2];
    logic [2:0] f3   [2];
    logic       f7   [2];
    logic [3:0] flg  [2];   // {Zero, Neg, Carry, Ovf}
    wire ctl_t  act0;
    wire ctl_t  act1;

    exp_t q0[$];
    exp_t q1[$];
    ctl_t seq[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mc_controller #(.ALUCTRL_W(3), .MEM_WAIT(0)) d0 (
        .clk(clk), .reset(rst[0]), .op(op[0]), .funct3(f3[0]), .funct7b5(f7[0]),
        .Zero(flg[0][3]), .Neg(flg[0][2]), .Carry(flg[0][1]), .Ovf(flg[0][0]),
        .PCWrite(act0.pcw), .AdrSrc(act0.adr), .MemWrite(act0.memw), .IRWrite(act0.irw),
        .RegWrite(act0.regw), .ResultSrc(act0.rs), .ALUSrcA(act0.sa), .ALUSrcB(act0.sb),
        .ImmSrc(act0.imm), .ALUControl(act0.alu[2:0]), .Retire(act0.ret), .Illegal(act0.ill)
    );
    assign act0.alu[3] = 1'b0;

    mc_controller #(.ALUCTRL_W(4), .MEM_WAIT(2)) d1 (
        .clk(clk), .reset(rst[1]), .op(op[1]), .funct3(f3[1]), .funct7b5(f7[1]),
        .Zero(flg[1][3]), .Neg(flg[1][2]), .Carry(flg[1][1]), .Ovf(flg[1][0]),
        .PCWrite(act1.pcw), .AdrSrc(act1.adr), .MemWrite(act1.memw), .IRWrite(act1.irw),
        .RegWrite(act1.regw), .ResultSrc(act1.rs), .ALUSrcA(act1.sa), .ALUSrcB(act1.sb),
        .ImmSrc(act1.imm), .ALUControl(act1.alu), .Retire(act1.ret), .Illegal(act1.ill)
    );

    task automatic check(input string tag, input ctl_t act, input ctl_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check(e.tag, act0, e.v);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check(e.tag, act1, e.v);
        end
    end

    // Expected control word for each controller state, as the datapath needs it.
    function automatic ctl_t mk(input logic pcw, adr, memw, irw, regw,
                                input logic [1:0] rs, sa, sb, input logic [2:0] imm,
                                input logic [3:0] alu, input logic ret, ill);
        mk = '{pcw, adr, memw, irw, regw, rs, sa, sb, imm, alu, ret, ill};
    endfunction

    function automatic ctl_t s_fetch(input logic [2:0] im, input logic fin);
        return mk(fin, 0, 0, fin, 0, 2'b10, 2'b00, 2'b10, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_decode(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_memadr(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_memrd(input logic [2:0] im);
        return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_memwb(input logic [2:0] im);
        return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 4'd0, 1, 0);
    endfunction
    function automatic ctl_t s_memwr(input logic [2:0] im, input logic fin);
        return mk(0, 1, fin, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'd0, fin, 0);
    endfunction
    function automatic ctl_t s_exec(input logic [2:0] im, input logic [1:0] sb, input logic [3:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, sb, im, alu, 0, 0);
    endfunction
    function automatic ctl_t s_aluwb(input logic [2:0] im);
        return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 4'd0, 1, 0);
    endfunction
    function automatic ctl_t s_jal(input logic [2:0] im);
        return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_src(input logic [2:0] im, input logic [1:0] sa);
        return mk(0, 0, 0, 0, 0, 2'b00, sa, 2'b01, im, 4'd0, 0, 0);
    endfunction
    function automatic ctl_t s_branch(input logic tk);
        return mk(tk, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, IM_B, 4'd1, 1, 0);
    endfunction
    function automatic ctl_t s_illegal(input logic [2:0] im);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 4'd0, 0, 1);
    endfunction

    task automatic set_in(input int d, input logic [6:0] o, input logic [2:0] fn3,
                          input logic b5, input logic [3:0] fl);
        op[d]  = o;
        f3[d]  = fn3;
        f7[d]  = b5;
        flg[d] = fl;
    endtask

    task automatic fetch(input int mw, input logic [2:0] im);
        for (int i = 0; i <= mw; i++) seq.push_back(s_fetch(im, i == mw));
    endtask

    // Hands the staged cycle list to the scoreboard and steps that many cycles;
    // reset is raised during cycle index rst_at (-1: never).
    task automatic issue(input int d, input string tag, input int rst_at);
        int n;
        n = seq.size();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.v   = seq[i];
            e.tag = $sformatf("%s[%0d]", tag, i);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        seq.delete();
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) rst[d] = 1'b1;
            @(posedge clk);
            #1;
            rst[d] = 1'b0;
        end
    endtask

    task automatic r_type(input int d, input int mw, input logic [2:0] fn3, input logic b5,
                          input logic [3:0] alu, input string tag);
        set_in(d, OP_R, fn3, b5, 4'h0);
        fetch(mw, IM_I);
        seq.push_back(s_decode(IM_I));
        seq.push_back(s_exec(IM_I, 2'b00, alu));
        seq.push_back(s_aluwb(IM_I));
        issue(d, tag, -1);
    endtask

    typedef struct { logic [2:0] f3; logic b5; logic [3:0] alu; } rvec_t;
    typedef struct { logic [2:0] f3; logic [3:0] fl; logic tk; } bvec_t;

    rvec_t r3[9] = '{
        '{3'b000, 1'b0, 4'd0}, '{3'b000, 1'b1, 4'd1}, '{3'b010, 1'b0, 4'd5},
        '{3'b100, 1'b0, 4'd4}, '{3'b110, 1'b0, 4'd3}, '{3'b111, 1'b0, 4'd2},
        '{3'b001, 1'b0, 4'd0}, '{3'b101, 1'b1, 4'd0}, '{3'b011, 1'b0, 4'd0}
    };
    rvec_t r4[6] = '{
        '{3'b101, 1'b1, 4'd9}, '{3'b101, 1'b0, 4'd8}, '{3'b001, 1'b0, 4'd7},
        '{3'b011, 1'b0, 4'd6}, '{3'b000, 1'b1, 4'd1}, '{3'b111, 1'b0, 4'd2}
    };
    bvec_t br[10] = '{
        '{3'b001, 4'b0000, 1'b1}, '{3'b001, 4'b1000, 1'b0}, '{3'b000, 4'b1000, 1'b1},
        '{3'b100, 4'b0101, 1'b0}, '{3'b101, 4'b0101, 1'b1}, '{3'b100, 4'b0100, 1'b1},
        '{3'b110, 4'b0000, 1'b1}, '{3'b111, 4'b0000, 1'b0}, '{3'b010, 4'b1000, 1'b0},
        '{3'b011, 4'b1111, 1'b0}
    };

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        set_in(0, 7'd0, 3'd0, 1'b0, 4'h0);
        set_in(1, 7'd0, 3'd0, 1'b0, 4'h0);
        @(posedge clk);
        #1;

        // ---------------- instance 0: ALUCTRL_W=3, MEM_WAIT=0 ----------------
        seq.push_back(s_fetch(IM_I, 1'b0));
        issue(0, "d0_reset", 0);

        foreach (r3[i]) r_type(0, 0, r3[i].f3, r3[i].b5, r3[i].alu, $sformatf("d0_r%0d", i));

        set_in(0, OP_I, 3'b000, 1'b1, 4'h0);
        fetch(0, IM_I); seq.push_back(s_decode(IM_I));
        seq.push_back(s_exec(IM_I, 2'b01, 4'd0)); seq.push_back(s_aluwb(IM_I));
        issue(0, "d0_addi_b5", -1);

        set_in(0, OP_I, 3'b100, 1'b0, 4'h0);
        fetch(0, IM_I); seq.push_back(s_decode(IM_I));
        seq.push_back(s_exec(IM_I, 2'b01, 4'd4)); seq.push_back(s_aluwb(IM_I));
        issue(0, "d0_xori", -1);

        foreach (br[i]) begin
            set_in(0, OP_BR, br[i].f3, 1'b0, br[i].fl);
            fetch(0, IM_B); seq.push_back(s_decode(IM_B)); seq.push_back(s_branch(br[i].tk));
            issue(0, $sformatf("d0_br%0d", i), -1);
        end

        set_in(0, OP_JAL, 3'b000, 1'b0, 4'h0);
        fetch(0, IM_J); seq.push_back(s_decode(IM_J));
        seq.push_back(s_jal(IM_J)); seq.push_back(s_aluwb(IM_J));
        issue(0, "d0_jal", -1);

        set_in(0, OP_JALR, 3'b000, 1'b0, 4'h0);
        fetch(0, IM_I); seq.push_back(s_decode(IM_I)); seq.push_back(s_src(IM_I, 2'b10));
        seq.push_back(s_jal(IM_I)); seq.push_back(s_aluwb(IM_I));
        issue(0, "d0_jalr", -1);

        set_in(0, OP_LUI, 3'b000, 1'b0, 4'h0);
        fetch(0, IM_U); seq.push_back(s_decode(IM_U));
        seq.push_back(s_src(IM_U, 2'b11)); seq.push_back(s_aluwb(IM_U));
        issue(0, "d0_lui", -1);

        set_in(0, OP_AUIPC, 3'b000, 1'b0, 4'h0);
        fetch(0, IM_U); seq.push_back(s_decode(IM_U));
        seq.push_back(s_src(IM_U, 2'b01)); seq.push_back(s_aluwb(IM_U));
        issue(0, "d0_auipc", -1);

        set_in(0, OP_LOAD, 3'b010, 1'b0, 4'h0);
        fetch(0, IM_I); seq.push_back(s_decode(IM_I)); seq.push_back(s_memadr(IM_I));
        seq.push_back(s_memrd(IM_I)); seq.push_back(s_memwb(IM_I));
        issue(0, "d0_lw", -1);

        set_in(0, OP_STORE, 3'b010, 1'b0, 4'h0);
        fetch(0, IM_S); seq.push_back(s_decode(IM_S)); seq.push_back(s_memadr(IM_S));
        seq.push_back(s_memwr(IM_S, 1'b1));
        issue(0, "d0_sw", -1);

        set_in(0, 7'b0000000, 3'b000, 1'b0, 4'h0);
        fetch(0, IM_I); seq.push_back(s_decode(IM_I)); seq.push_back(s_illegal(IM_I));
        issue(0, "d0_illegal", -1);
        r_type(0, 0, 3'b000, 1'b0, 4'd0, "d0_after_illegal");

        set_in(0, OP_STORE, 3'b010, 1'b0, 4'h0);
        fetch(0, IM_S); seq.push_back(s_decode(IM_S)); seq.push_back(s_memadr(IM_S));
        seq.push_back(s_memwr(IM_S, 1'b0));
        issue(0, "d0_sw_reset", 3);
        r_type(0, 0, 3'b110, 1'b0, 4'd3, "d0_after_reset");

        // ---------------- instance 1: ALUCTRL_W=4, MEM_WAIT=2 ----------------
        seq.push_back(s_fetch(IM_I, 1'b0));
        issue(1, "d1_reset", 0);

        set_in(1, OP_LOAD, 3'b010, 1'b0, 4'h0);
        fetch(2, IM_I); seq.push_back(s_decode(IM_I)); seq.push_back(s_memadr(IM_I));
        for (int i = 0; i < 3; i++) seq.push_back(s_memrd(IM_I));
        seq.push_back(s_memwb(IM_I));
        issue(1, "d1_lw", -1);

        set_in(1, OP_STORE, 3'b010, 1'b0, 4'h0);
        fetch(2, IM_S); seq.push_back(s_decode(IM_S)); seq.push_back(s_memadr(IM_S));
        for (int i = 0; i < 3; i++) seq.push_back(s_memwr(IM_S, i == 2));
        issue(1, "d1_sw", -1);

        foreach (r4[i]) r_type(1, 2, r4[i].f3, r4[i].b5, r4[i].alu, $sformatf("d1_r%0d", i));

        set_in(1, OP_I, 3'b101, 1'b1, 4'h0);
        fetch(2, IM_I); seq.push_back(s_decode(IM_I));
        seq.push_back(s_exec(IM_I, 2'b01, 4'd9)); seq.push_back(s_aluwb(IM_I));
        issue(1, "d1_srai", -1);

        set_in(1, OP_LUI, 3'b000, 1'b0, 4'h0);
        fetch(2, IM_U); seq.push_back(s_decode(IM_U));
        seq.push_back(s_src(IM_U, 2'b11)); seq.push_back(s_aluwb(IM_U));
        issue(1, "d1_lui", -1);

        set_in(1, OP_STORE, 3'b010, 1'b0, 4'h0);
        fetch(2, IM_S); seq.push_back(s_decode(IM_S)); seq.push_back(s_memadr(IM_S));
        for (int i = 0; i < 3; i++) seq.push_back(s_memwr(IM_S, 1'b0));
        issue(1, "d1_sw_reset", 7);
        r_type(1, 2, 3'b100, 1'b0, 4'd4, "d1_after_reset");

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q0.size() + q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
